crc8_frame_ctrl: RTL

// Byte-level sequencer for the bit-serial CRC-8/EBU engine. Accepts a framed byte stream
// (valid/ready/last) and feeds each byte LSB-first into an internal 8-bit LFSR, one bit per clock.

---
 rtl/crc8_frame_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/crc8_frame_ctrl.sv
// Byte sequencer for a bit-serial CRC-8 LFSR: shifts each framed byte LSB-first,
// forwards it downstream, then appends the CRC (generate) or flags the residue (check).
module crc8_frame_ctrl #(
  parameter bit         CHECK_MODE = 1'b0,
  parameter logic [7:0] POLY       = 8'h1D,
  parameter logic [7:0] INIT       = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       abort,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic [7:0] crc_value,
  output logic       crc_done,
  output logic       crc_ok,
  output logic       busy
);

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {IDLE, SHIFT, EMIT, APPEND} state_t;

  state_t        state, state_d;
  logic [W-1:0]  lfsr, lfsr_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [W-1:0]  byte_q, byte_d;
  logic          last_q, last_d;
  logic [W-1:0]  out_data_d;
  logic          out_last_d, out_valid_d, in_ready_d, busy_d, crc_done_d, crc_ok_d;

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s, input logic b);
    logic fb;
    fb = s[W-1] ^ b;
    return {s[W-2:0], 1'b0} ^ ({W{fb}} & POLY);
  endfunction

  // Running CRC is the LFSR read out bit-reversed (reflected output).
  for (genvar i = 0; i < W; i++) begin : g_rev
    assign crc_value[i] = lfsr[W-1-i];
  end

  always_comb begin
    state_d    = state;
    lfsr_d     = lfsr;
    cnt_d      = cnt;
    byte_d     = byte_q;
    last_d     = last_q;
    out_data_d = out_data;
    out_last_d = out_last;
    crc_done_d = 1'b0;
    crc_ok_d   = crc_ok;

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          byte_d  = in_data;
          last_d  = in_last;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        lfsr_d = lfsr_step(lfsr, byte_q[cnt]);
        cnt_d  = cnt + CW'(1);
        if (cnt == CW'(7)) begin
          state_d    = EMIT;
          out_data_d = byte_q;
          out_last_d = last_q & CHECK_MODE;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (!last_q) begin
            state_d = IDLE;
          end else if (!CHECK_MODE) begin
            state_d    = APPEND;
            out_data_d = crc_value;
            out_last_d = 1'b1;
          end else begin
            crc_done_d = 1'b1;
            crc_ok_d   = (lfsr == '0);
            lfsr_d     = INIT;
            state_d    = IDLE;
          end
        end
      end
      APPEND: begin
        if (out_ready) begin
          crc_done_d = 1'b1;
          lfsr_d     = INIT;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort discards the frame in progress; crc_ok keeps its last verdict.
    if (abort) begin
      state_d    = IDLE;
      lfsr_d     = INIT;
      crc_done_d = 1'b0;
      crc_ok_d   = crc_ok;
    end

    out_valid_d = (state_d == EMIT) || (state_d == APPEND);
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= INIT;
      cnt       <= '0;
      byte_q    <= '0;
      last_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      crc_done  <= 1'b0;
      crc_ok    <= 1'b0;
    end else begin
      state     <= state_d;
      lfsr      <= lfsr_d;
      cnt       <= cnt_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_last  <= out_last_d;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
      crc_done  <= crc_done_d;
      crc_ok    <= crc_ok_d;
    end
  end

endmodule
